// File: rtl/axis_frame_rx.sv
// axis_frame_rx
//   AXI4-Stream video sink. Locks to start-of-frame (TUSER), tracks raster
//   coordinates against the configured geometry, and forwards each pixel to
//   the processing core through a single output register. Framing errors are
//   flagged in sticky bits and recovered from without stalling the stream.
//
// Ports
//   i_clk, i_rstn        clock, synchronous active-low reset
//   i_enable             allow locking to a new frame
//   S_AXIS_*             input pixel stream (TUSER = SOF, TLAST = EOL)
//   o_pix_* / o_x / o_y  output pixel, coordinates, frame markers
//   i_pix_ready          core-side ready
//   o_frame_count        completed frames (wrapping)
//   o_err_short/long/sof sticky framing errors, cleared by i_clr_err
module axis_frame_rx #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int FRAME_WIDTH  = 640,
    parameter  int FRAME_HEIGHT = 480,
    localparam int X_W          = $clog2(FRAME_WIDTH),
    localparam int Y_W          = $clog2(FRAME_HEIGHT)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_enable,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TUSER,
    input  logic                  S_AXIS_TLAST,
    output logic                  o_pix_valid,
    input  logic                  i_pix_ready,
    output logic [DATA_WIDTH-1:0] o_pix_data,
    output logic [X_W-1:0]        o_x,
    output logic [Y_W-1:0]        o_y,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_eof,
    output logic [15:0]           o_frame_count,
    output logic                  o_err_short,
    output logic                  o_err_long,
    output logic                  o_err_sof,
    input  logic                  i_clr_err
);

    localparam logic [X_W-1:0] X_MAX = X_W'(FRAME_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        DROP_LINE
    } state_t;

    state_t         state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;

    logic           beat;
    logic           fwd;
    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;
    logic           at_end;
    logic           eol;
    logic           eof;
    logic           set_short;
    logic           set_long;
    logic           set_sof;

    always_comb begin
        case (state)
            WAIT_SOF:  S_AXIS_TREADY = i_enable;
            DROP_LINE: S_AXIS_TREADY = 1'b1;
            default:   S_AXIS_TREADY = !o_pix_valid || i_pix_ready;
        endcase
    end

    assign beat = S_AXIS_TVALID && S_AXIS_TREADY;

    // Outside ACTIVE only a frame-start beat is forwarded; everything else
    // is swallowed while (re)locking.
    assign fwd  = beat && (S_AXIS_TUSER || state == ACTIVE);

    // A TUSER beat always lands at (0,0); the line rules below then apply to
    // it exactly as to any other pixel.
    assign px     = S_AXIS_TUSER ? '0 : x;
    assign py     = S_AXIS_TUSER ? '0 : y;
    assign at_end = (px == X_MAX);
    assign eol    = S_AXIS_TLAST || at_end;
    assign eof    = eol && (py == Y_MAX);

    assign set_short = fwd && S_AXIS_TLAST && !at_end;
    assign set_long  = fwd && !S_AXIS_TLAST && at_end;
    assign set_sof   = beat && S_AXIS_TUSER &&
                       (state == DROP_LINE ||
                        (state == ACTIVE && (x != '0 || y != '0)));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state         <= WAIT_SOF;
            x             <= '0;
            y             <= '0;
            o_pix_valid   <= 1'b0;
            o_pix_data    <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_sof         <= 1'b0;
            o_eol         <= 1'b0;
            o_eof         <= 1'b0;
            o_frame_count <= '0;
            o_err_short   <= 1'b0;
            o_err_long    <= 1'b0;
            o_err_sof     <= 1'b0;
        end else begin
            // Set beats a simultaneous clear.
            o_err_short <= set_short || (o_err_short && !i_clr_err);
            o_err_long  <= set_long  || (o_err_long  && !i_clr_err);
            o_err_sof   <= set_sof   || (o_err_sof   && !i_clr_err);

            if (fwd) begin
                o_pix_valid <= 1'b1;
                o_pix_data  <= S_AXIS_TDATA;
                o_x         <= px;
                o_y         <= py;
                o_sof       <= (px == '0) && (py == '0);
                o_eol       <= eol;
                o_eof       <= eof;
                if (eof) begin
                    // Leftover beats of an over-long last line are dropped
                    // by WAIT_SOF itself, so no DROP_LINE detour here.
                    x             <= '0;
                    y             <= '0;
                    state         <= WAIT_SOF;
                    o_frame_count <= o_frame_count + 16'd1;
                end else if (eol) begin
                    x     <= '0;
                    y     <= py + Y_W'(1);
                    state <= set_long ? DROP_LINE : ACTIVE;
                end else begin
                    x     <= px + X_W'(1);
                    y     <= py;
                    state <= ACTIVE;
                end
            end else begin
                if (i_pix_ready)
                    o_pix_valid <= 1'b0;
                // The TLAST beat closing a dropped tail is itself discarded.
                if (beat && state == DROP_LINE && S_AXIS_TLAST)
                    state <= ACTIVE;
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_rx.sv
module tb_axis_frame_rx;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          en;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tuser;
    logic          tlast;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic [1:0]    px_o;
    logic [0:0]    py_o;
    logic          sof_o, eol_o, eof_o;
    logic [15:0]   fcount;
    logic          e_short, e_long, e_sof;
    logic          clr;

    axis_frame_rx #(.DATA_WIDTH(DW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_enable(en),
        .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready), .S_AXIS_TDATA(tdata),
        .S_AXIS_TUSER(tuser), .S_AXIS_TLAST(tlast),
        .o_pix_valid(pix_valid), .i_pix_ready(pix_ready), .o_pix_data(pix_data),
        .o_x(px_o), .o_y(py_o), .o_sof(sof_o), .o_eol(eol_o), .o_eof(eof_o),
        .o_frame_count(fcount), .o_err_short(e_short), .o_err_long(e_long),
        .o_err_sof(e_sof), .i_clr_err(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: follows the framing rules on every accepted beat and
    // queues the pixel the core should see, with its coordinates and markers.
    logic [37:0] expq[$];
    int          mode;     // 0 = hunting for SOF, 1 = in frame, 2 = dropping line tail
    int          mx, my;
    bit          m_short, m_long, m_sof;
    int          mcount;

    task automatic model_beat(input logic [DW-1:0] d, input bit u, input bit l);
        int px, py;
        bit e_l, e_f, s_f;
        if (mode == 0 && !u) return;
        if (mode == 2 && !u) begin
            if (l) mode = 1;
            return;
        end
        if (u) begin
            if (mode == 2 || (mode == 1 && (mx != 0 || my != 0))) m_sof = 1;
            px = 0; py = 0;
        end else begin
            px = mx; py = my;
        end
        e_l = l || (px == W - 1);
        e_f = e_l && (py == H - 1);
        s_f = (px == 0) && (py == 0);
        if (l && px < W - 1)   m_short = 1;
        if (!l && px == W - 1) m_long  = 1;
        expq.push_back({d, 2'(px), 1'(py), s_f, e_l, e_f});
        if (e_f) begin
            mode = 0; mx = 0; my = 0;
            mcount = (mcount + 1) % 65536;
        end else if (e_l) begin
            mx = 0; my = py + 1;
            mode = l ? 1 : 2;
        end else begin
            mx = px + 1; my = py; mode = 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            mode = 0; mx = 0; my = 0; mcount = 0;
            m_short = 0; m_long = 0; m_sof = 0;
            expq.delete();
        end else begin
            if (pix_valid && pix_ready) begin
                if (expq.size() == 0)
                    chk("pix_unexpected", 64'(pix_data), 64'hdead_0000_0000);
                else
                    chk("pix", 64'({pix_data, px_o, py_o, sof_o, eol_o, eof_o}),
                        64'(expq.pop_front()));
            end
            if (clr) begin
                m_short = 0; m_long = 0; m_sof = 0;
            end
            if (tvalid && tready) model_beat(tdata, tuser, tlast);
        end
    end

    bit bub = 0;

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input bit u, input bit l);
        int t = 0;
        tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
        @(negedge clk);
        while (!tready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("tready_timeout", 64'(t < 100), 64'd1);
        @(posedge clk); #1;
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
        if (bub && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic line(input int len, input bit first);
        for (int i = 0; i < len; i++)
            send($urandom, first && i == 0, i == len - 1);
    endtask

    task automatic frame();
        line(W, 1);
        line(W, 0);
    endtask

    task automatic settle();
        tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    logic [DW-1:0] d1;

    initial begin
        rstn = 0; en = 0; tvalid = 0; tdata = '0; tuser = 0; tlast = 0;
        pix_ready = 1; clr = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_outputs", 64'({pix_valid, pix_data, px_o, py_o, sof_o, eol_o, eof_o,
                                e_short, e_long, e_sof}), 64'd0);
        chk("rst_count", 64'(fcount), 64'd0);
        chk("rst_tready_disabled", 64'(tready), 64'd0);
        @(posedge clk); #1;
        rstn = 1;

        // Disabled: a presented SOF beat is not taken.
        tvalid = 1; tdata = 32'h1234_5678; tuser = 1;
        repeat (2) @(negedge clk);
        chk("en_low_tready", 64'(tready), 64'd0);
        @(posedge clk); #1;
        tvalid = 0; tuser = 0; en = 1;

        // Clean frame.
        frame();
        settle();
        chk("clean_count", 64'(fcount), 64'd1);
        chk("clean_flags", 64'({e_short, e_long, e_sof}), 64'd0);

        // Pre-lock garbage then a clean frame.
        for (int i = 0; i < 3; i++) send($urandom, 0, i == 2);
        frame();
        settle();
        chk("garbage_count", 64'(fcount), 64'd2);

        // Backpressure mid-line.
        @(posedge clk); #1;
        send($urandom, 1, 0);
        d1 = $urandom;
        send(d1, 0, 0);
        pix_ready = 0;
        tvalid = 1; tdata = 32'hcafe_0002; tuser = 0; tlast = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_tready", 64'(tready), 64'd0);
            chk("bp_data", 64'(pix_data), 64'(d1));
            chk("bp_x", 64'(px_o), 64'd1);
        end
        @(posedge clk); #1;
        pix_ready = 1;
        send(32'hcafe_0002, 0, 0);
        send($urandom, 0, 1);
        line(W, 0);
        settle();
        chk("bp_count", 64'(fcount), 64'd3);
        chk("bp_flags", 64'({e_short, e_long, e_sof}), 64'd0);

        // Long line: three extra beats, the last one carrying TLAST.
        @(posedge clk); #1;
        line(W + 3, 1);
        line(W, 0);
        settle();
        chk("long_flags", 64'({e_short, e_long, e_sof}), 64'b010);
        chk("long_count", 64'(fcount), 64'd4);

        // Short line, with a clear landing on the short beat itself.
        @(posedge clk); #1;
        send($urandom, 1, 0);
        clr = 1;
        send($urandom, 0, 1);
        clr = 0;
        line(W, 0);
        settle();
        chk("short_flags", 64'({e_short, e_long, e_sof}), 64'b100);
        chk("short_count", 64'(fcount), 64'd5);

        @(posedge clk); #1;
        pulse_clr();
        settle();
        chk("clr1_flags", 64'({e_short, e_long, e_sof}), 64'd0);

        // TUSER at (2,0) restarts the frame.
        @(posedge clk); #1;
        send($urandom, 1, 0);
        send($urandom, 0, 0);
        send($urandom, 1, 0);
        send($urandom, 0, 0);
        send($urandom, 0, 0);
        send($urandom, 0, 1);
        line(W, 0);
        settle();
        chk("midsof_flags", 64'({e_short, e_long, e_sof}), 64'b001);
        chk("midsof_count", 64'(fcount), 64'd6);
        @(posedge clk); #1;
        pulse_clr();
        settle();
        chk("clr2_flags", 64'({e_short, e_long, e_sof}), 64'd0);

        // Randomized frames: random payload, bubbles and line lengths.
        @(posedge clk); #1;
        bub = 1;
        for (int f = 0; f < 12; f++) begin
            for (int r = 0; r < H; r++) begin
                if ($urandom_range(0, 9) < 6) line(W, r == 0);
                else line($urandom_range(1, W + 3), r == 0);
            end
        end
        bub = 0;
        settle();
        chk("rand_count", 64'(fcount), 64'(mcount));
        chk("rand_flags", 64'({e_short, e_long, e_sof}), 64'({m_short, m_long, m_sof}));

        // Reset mid-frame abandons the partial frame.
        @(posedge clk); #1;
        send($urandom, 1, 0);
        send($urandom, 0, 0);
        rstn = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_count", 64'(fcount), 64'd0);
        chk("midrst_valid", 64'(pix_valid), 64'd0);
        @(posedge clk); #1;
        rstn = 1;
        frame();
        settle();
        chk("post_rst_count", 64'(fcount), 64'd1);

        chk("exp_drained", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
